// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: state encoding and fixed register map shared by the register-bus slave
package reg_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int ADDR_ID = 0;
    localparam int ADDR_WR_COUNT = 1;
    localparam int FIRST_RW = 2;
endpackage

// File: rtl/reg_bus_if.sv
// reg_bus_if: request/acknowledge register bus between a master and a slave
interface reg_bus_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic req;
    logic write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0] data_out;
    logic ack;
    logic err;
    logic busy;
    modport master (output req, write, address, data_in, wstrb, input data_out, ack, err, busy);
    modport slave (input req, write, address, data_in, wstrb, output data_out, ack, err, busy);
endinterface

// File: rtl/reg_bus_regfile.sv
// reg_bus_regfile: ID/WR_COUNT/R-W storage with byte-strobe writes, read mux and address checking
module reg_bus_regfile import reg_bus_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_REGS = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(16'hA5C3),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic commit,
    input  logic write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic illegal
);
    logic [DATA_W-1:0] regs [FIRST_RW:NUM_REGS-1];
    logic [DATA_W-1:0] wr_count;
    logic [31:0] a;
    logic we;
    assign a = 32'(address);
    assign illegal = a >= NUM_REGS || (write && a < FIRST_RW);
    assign we = commit && write && !illegal;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_count <= '0;
            for (int i = FIRST_RW; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (we) begin
            wr_count <= wr_count + 1'b1;
            for (int i = FIRST_RW; i < NUM_REGS; i++)
                for (int b = 0; b < DATA_W / 8; b++)
                    if (a == 32'(i) && wstrb[b]) regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    // out-of-range addresses fall through to zero
    always_comb begin
        rdata = '0;
        if (a == ADDR_ID) rdata = ID_VALUE;
        if (a == ADDR_WR_COUNT) rdata = wr_count;
        for (int i = FIRST_RW; i < NUM_REGS; i++)
            if (a == 32'(i)) rdata = regs[i];
    end
endmodule

// File: rtl/reg_bus_slave.sv
// reg_bus_slave: register-bus target with configurable ack latency, byte strobes and error response
module reg_bus_slave import reg_bus_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int NUM_REGS = 16,
    parameter int LATENCY = 1,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(16'hA5C3),
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input logic clk,
    input logic rst_n,
    reg_bus_if.slave bus
);
    typedef struct packed {
        logic write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
        logic [DATA_W/8-1:0] strb;
    } req_t;
    state_t state;
    req_t cap;
    logic [1:0] cnt;
    logic commit;
    logic illegal;
    logic [DATA_W-1:0] rdata;
    assign commit = state == WAIT && cnt == '0;
    reg_bus_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
        .ID_VALUE(ID_VALUE), .RESET_VAL(RESET_VAL)
    ) u_regfile (
        .clk(clk), .rst_n(rst_n), .commit(commit), .write(cap.write), .address(cap.address),
        .wdata(cap.data), .wstrb(cap.strb), .rdata(rdata), .illegal(illegal)
    );
    // WAIT always spans LATENCY cycles so ack rises exactly LATENCY edges after the sample
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cap <= '0;
            cnt <= '0;
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            bus.busy <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.ack <= commit;
            case (state)
                IDLE: if (bus.req) begin
                    state <= WAIT;
                    cap <= {bus.write, bus.address, bus.data_in, bus.wstrb};
                    cnt <= 2'(LATENCY - 1);
                    bus.busy <= 1'b1;
                end
                WAIT: if (commit) begin
                    state <= RESP;
                    bus.err <= illegal;
                    if (!cap.write) bus.data_out <= rdata;
                end else cnt <= cnt - 1'b1;
                RESP: begin
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_reg_bus_slave.sv
// tb_reg_bus_slave: two slaves (16-bit LATENCY=1, 8-bit LATENCY=3) checked against a transaction-level model
module tb_reg_bus_slave;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst [2];
    logic req [2], wr [2], ack [2], err [2], busy [2];
    logic [7:0] addr [2];
    logic [15:0] din [2], dout [2];
    logic [1:0] strb [2];
    for (genvar g = 0; g < 2; g++) begin : gd
        localparam int DW = g ? 8 : 16;
        reg_bus_if #(.DATA_W(DW), .ADDR_W(8)) bi ();
        assign bi.req = req[g];
        assign bi.write = wr[g];
        assign bi.address = addr[g];
        assign bi.data_in = din[g][DW-1:0];
        assign bi.wstrb = strb[g][DW/8-1:0];
        assign ack[g] = bi.ack;
        assign err[g] = bi.err;
        assign busy[g] = bi.busy;
        assign dout[g] = 16'(bi.data_out);
        reg_bus_slave #(
            .DATA_W(DW), .ADDR_W(8), .NUM_REGS(g ? 8 : 16), .LATENCY(g ? 3 : 1),
            .ID_VALUE(DW'(g ? 16'h005A : 16'hA5C3)), .RESET_VAL('0)
        ) dut (.clk(clk), .rst_n(rst[g]), .bus(bi));
    end
    int lat [2] = '{1, 3};
    int nregs [2] = '{16, 8};
    int nb [2] = '{2, 1};
    logic [15:0] idv [2] = '{16'hA5C3, 16'h005A};
    logic [15:0] mask [2] = '{16'hFFFF, 16'h00FF};
    logic [15:0] mem [2][256];
    logic [15:0] wcnt [2], dout_exp [2], t_rd [2];
    logic t_w [2], t_err [2], t_act [2], chk_en [2];
    int t_e0 [2];
    int ncyc = 0;
    int cmp = 0, bad = 0;
    int g_ack, g_rel;
    logic g_err;
    logic [15:0] g_do;
    always @(posedge clk) ncyc <= ncyc + 1;
    task automatic chk(input int k, input string n, input logic [15:0] act, input logic [15:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %h want %h (cycle %0d)", k, n, act, exp, ncyc);
        end
    endtask
    task automatic mreset(input int k);
        for (int i = 0; i < 256; i++) mem[k][i] = '0;
        wcnt[k] = '0;
        dout_exp[k] = '0;
        t_act[k] = 1'b0;
    endtask
    task automatic model(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                         input logic [1:0] s, output logic e, output logic [15:0] r);
        r = '0;
        e = 1'b0;
        if (int'(a) >= nregs[k]) e = 1'b1;
        else if (w) begin
            if (a < 8'd2) e = 1'b1;
            else begin
                for (int b = 0; b < nb[k]; b++) if (s[b]) mem[k][a][b*8 +: 8] = d[b*8 +: 8];
                wcnt[k] = (wcnt[k] + 16'd1) & mask[k];
            end
        end else r = a == 8'd0 ? idv[k] : a == 8'd1 ? wcnt[k] : mem[k][a];
    endtask
    // called at a negedge with the slave idle; returns at the negedge where the next request may start
    task automatic xact(input int k, input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic hold);
        logic e;
        logic [15:0] r;
        model(k, w, a, d, s, e, r);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; din[k] = d; strb[k] = s;
        t_w[k] = w; t_rd[k] = r; t_err[k] = e; t_e0[k] = ncyc + 1; t_act[k] = 1'b1;
        g_ack = 0; g_rel = -1; g_err = 1'b0; g_do = '0;
        for (int i = 0; i <= lat[k] + 1; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req[k] = hold; wr[k] = 1'($urandom); addr[k] = 8'($urandom);
                din[k] = 16'($urandom); strb[k] = 2'($urandom);
            end
            if (ack[k]) begin g_ack++; g_rel = i; g_err = err[k]; g_do = dout[k]; end
        end
        if (!w) dout_exp[k] = r;
        t_act[k] = 1'b0;
    endtask
    always @(negedge clk)
        for (int k = 0; k < 2; k++) if (chk_en[k]) begin
            automatic int rel = ncyc - t_e0[k];
            automatic logic live = t_act[k] && rel >= 0;
            automatic logic ea = live && rel == lat[k];
            chk(k, "ack", 16'(ack[k]), 16'(ea));
            chk(k, "busy", 16'(busy[k]), 16'(live && rel <= lat[k]));
            chk(k, "data_out", dout[k], (live && rel >= lat[k] && !t_w[k]) ? t_rd[k] : dout_exp[k]);
            if (ea) chk(k, "err", 16'(err[k]), 16'(t_err[k]));
        end
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0; chk_en[k] = 1'b1; req[k] = 1'b0; wr[k] = 1'b0;
            addr[k] = '0; din[k] = '0; strb[k] = '0; t_e0[k] = 0; t_w[k] = 1'b0;
            t_rd[k] = '0; t_err[k] = 1'b0;
            mreset(k);
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(negedge clk);
        xact(0, 1'b0, 8'h00, 16'h0, 2'b00, 1'b0);
        chk(0, "t1_id", g_do, 16'hA5C3);
        chk(0, "t1_err", 16'(g_err), 16'h0);
        chk(0, "t1_ack_edge", 16'(g_rel), 16'd1);
        chk(0, "t1_ack_count", 16'(g_ack), 16'd1);
        xact(0, 1'b0, 8'h01, 16'h0, 2'b00, 1'b0);
        chk(0, "t1_wrcount", g_do, 16'h0000);
        xact(0, 1'b1, 8'h05, 16'h1234, 2'b11, 1'b0);
        xact(0, 1'b1, 8'h05, 16'hABCD, 2'b01, 1'b0);
        xact(0, 1'b0, 8'h05, 16'h0, 2'b00, 1'b0);
        chk(0, "t2_strobe", g_do, 16'h12CD);
        xact(0, 1'b0, 8'h01, 16'h0, 2'b00, 1'b0);
        chk(0, "t2_wrcount", g_do, 16'h0002);
        xact(0, 1'b1, 8'h00, 16'hFFFF, 2'b11, 1'b0);
        chk(0, "t3_ro_err", 16'(g_err), 16'h1);
        xact(0, 1'b0, 8'h00, 16'h0, 2'b00, 1'b0);
        chk(0, "t3_id_kept", g_do, 16'hA5C3);
        xact(0, 1'b0, 8'h01, 16'h0, 2'b00, 1'b0);
        chk(0, "t3_wrcount_kept", g_do, 16'h0002);
        xact(0, 1'b0, 8'hFF, 16'h0, 2'b00, 1'b0);
        chk(0, "t3_range_err", 16'(g_err), 16'h1);
        chk(0, "t3_range_data", g_do, 16'h0000);
        repeat (300) begin
            automatic logic [7:0] a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
            xact(0, 1'($urandom), a, 16'($urandom), 2'($urandom), 1'b0);
        end
        xact(1, 1'b0, 8'h01, 16'h0, 2'b00, 1'b1);
        chk(1, "t4_ack_edge", 16'(g_rel), 16'd3);
        chk(1, "t4_ack_count", 16'(g_ack), 16'd1);
        chk(1, "t4_wrcount", g_do, 16'h0000);
        xact(1, 1'b0, 8'h00, 16'h0, 2'b00, 1'b0);
        chk(1, "t4_id", g_do, 16'h005A);
        chk_en[1] = 1'b0;
        req[1] = 1'b1; wr[1] = 1'b1; addr[1] = 8'h02; din[1] = 16'h0055; strb[1] = 2'b01;
        @(negedge clk);
        req[1] = 1'b0;
        chk(1, "t5_busy_before", 16'(busy[1]), 16'h1);
        @(posedge clk);
        #1 rst[1] = 1'b0;
        #1;
        chk(1, "t5_ack_reset", 16'(ack[1]), 16'h0);
        chk(1, "t5_busy_reset", 16'(busy[1]), 16'h0);
        chk(1, "t5_dout_reset", dout[1], 16'h0000);
        mreset(1);
        @(negedge clk);
        rst[1] = 1'b1;
        chk_en[1] = 1'b1;
        xact(1, 1'b0, 8'h02, 16'h0, 2'b00, 1'b0);
        chk(1, "t5_abandoned", g_do, 16'h0000);
        xact(1, 1'b0, 8'h01, 16'h0, 2'b00, 1'b0);
        chk(1, "t5_wrcount", g_do, 16'h0000);
        repeat (257) xact(1, 1'b1, 8'h03, 16'($urandom), 2'($urandom), 1'b0);
        xact(1, 1'b0, 8'h01, 16'h0, 2'b00, 1'b0);
        chk(1, "t6_wrap", g_do, 16'h0001);
        repeat (80) xact(1, 1'($urandom), 8'($urandom_range(0, 9)), 16'($urandom), 2'($urandom), 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
